dma_data_receive: RTL
=====================

Name: dma_data_receive

Overview:
Consumer end of the GPU page-ring DMA protocol. The ring producer writes data pages into GPU memory and posts a 64-byte control record per page into the control ring. This block reads the pages back into the FPGA:
- It waits for the producer count to run ahead of its own count.
- It fetches the next control record over DMA read, then fetches the page that record describes.
- It checks the page payload pattern and publishes its consumed-page count, which the producer uses for flow control.

Parameters:
PAGE_SIZE, 2*1024*1024, bytes per data page; also the stride between pages.
CTRL_NUM, 1024, number of 64-byte slots in the control ring at transfer_base_addr.

Ports:
clk  in  1  user clock
rstn  in  1  synchronous active-low reset
axis_dma_read_cmd  axis_mem_cmd.master  address 64, length 32, valid/ready  DMA read commands
axis_dma_read_data  axi_stream.slave  data 512, keep 64, last, valid/ready  DMA read data
transfer_base_addr  in  64  control ring base; page 0 sits at base + transfer_start_page*PAGE_SIZE
transfer_start_page  in  32  first data page index
transfer_length  in  32  total payload bytes to consume (multiple of 64)
transfer_offset  in  32  expected-pattern offset
work_page_size  in  32  number of pages in the data ring
transfer_start  in  1  level; rising edge starts a run
gpu_write_count  in  32  producer page count (free-running, wraps)
gpu_read_count  out  32  pages consumed (free-running, wraps)
error_cnt  out  32  payload/protocol errors since start
error_index  out  32  beat index of first payload error
rx_done  out  1  high from END until next start

Behaviour:
- Interface decided: one clock `clk`; reset `rstn` is synchronous and active-low.
- Reset values: all outputs 0; cmd valid 0; data ready 0; state IDLE. Asserting rstn mid-run aborts immediately; no cleanup of outstanding DMA.
- Start detection:
  - transfer_start is registered twice; a rise between the stages is a start edge, one cycle after the input rises.
  - A start edge is honoured only in IDLE and is ignored elsewhere.
- Latched at START: base addresses, remain = transfer_length, expected ctrl index 0, error_cnt/error_index 0, rx_done 0. gpu_read_count is not cleared; it is free-running.
- States: IDLE, START, WAIT_AVAIL, CTRL_CMD, CTRL_DATA, DATA_CMD, DATA_DATA, JUDGE, END.
- IDLE -> START on start edge.
- START -> WAIT_AVAIL.
- WAIT_AVAIL -> CTRL_CMD when (gpu_write_count - gpu_read_count) mod 2^32 is nonzero.
- CTRL_CMD:
  - Drives valid with address = transfer_base_addr + 64*ctrl_idx and length 0x40.
  - Valid stays high until ready; -> CTRL_DATA on handshake.
- CTRL_DATA:
  - ready=1; accepts one beat, which must carry last.
  - Record fields: [511] flag, [95:64] page index, [63:32] ctrl index, [31:0] length.
  - Record OK when: flag=1, ctrl index == ctrl_idx, page index < work_page_size, length nonzero, length multiple of 64, length <= PAGE_SIZE.
  - OK -> DATA_CMD.
  - flag=0 or ctrl index mismatch (producer record not yet visible) -> WAIT_AVAIL to re-poll, with no count change.
  - Any other bad field -> error_cnt+1, then END.
- DATA_CMD:
  - Address = start_addr + page_index*PAGE_SIZE (64-bit arithmetic); length = record length.
  - -> DATA_DATA on handshake.
- DATA_DATA:
  - ready=1; beat counter b starts at 0.
  - Each accepted beat: compare data[31:0] against b + transfer_offset (32-bit wrap).
  - On mismatch: error_cnt+1; on the first mismatch of the run, error_index = b.
  - Exit after beat (length>>6)-1 is accepted.
  - last asserted on any other beat, or absent on the final beat -> error_cnt+1; the exit is still by count.
- JUDGE (one cycle):
  - gpu_read_count+1; remain -= length, saturating at 0.
  - ctrl_idx+1, wrapping to 0 at CTRL_NUM.
  - remain == 0 -> END, else WAIT_AVAIL.
- END: rx_done=1 -> IDLE. rx_done stays 1 until the next START.
- Ready is 0 outside CTRL_DATA/DATA_DATA. Cmd valid is 0 outside CTRL_CMD/DATA_CMD.
- Counter wrap: gpu_read_count wraps 0xFFFF_FFFF -> 0; the availability test uses modular subtraction, so it is correct across the wrap.

Test Plan:
- Single page: length 0x1000, offset 5, gpu_write_count 1, valid record {flag,page 0,ctrl 0,len 0x1000} -> commands:
  - ctrl read @base, len 0x40;
  - data read @base+start_page*PAGE_SIZE, len 0x1000;
  - 64 beats, error_cnt 0, gpu_read_count 1, rx_done 1.
- Flow control: length 3*PAGE_SIZE, gpu_write_count held at 1 -> block stalls in WAIT_AVAIL after page 1 with no cmd valid; raising gpu_write_count to 3 -> two more pages consumed, gpu_read_count 3, ctrl addresses base+0x40 and base+0x80.
- Stale record: first ctrl beat has flag=0 -> re-poll of the same address; second poll valid -> normal completion with error_cnt 0.
- Payload error: beat 7 carries wrong data[31:0] and beat 9 also wrong -> error_cnt 2, error_index 7.
- Wrap: gpu_read_count preset 0xFFFF_FFFF via prior runs, gpu_write_count 0 -> page consumed, gpu_read_count 0. With CTRL_NUM=4 and 5 pages, the fifth ctrl read targets base+0.
- Reset mid-run: rstn low during DATA_DATA -> next cycle state IDLE, outputs 0; a new start edge runs cleanly.

Source files
------------

// File: rtl/dma_data_receive.sv
// dma_data_receive: consumer end of the GPU page ring; polls control records, reads pages back
// and checks their payload pattern, publishing the consumed-page count for producer flow control.
module dma_data_receive #(
  parameter int PAGE_SIZE = 2*1024*1024,
  parameter int CTRL_NUM  = 1024
) (
  input  logic         clk,
  input  logic         rstn,
  output logic         axis_dma_read_cmd_valid,
  input  logic         axis_dma_read_cmd_ready,
  output logic [63:0]  axis_dma_read_cmd_address,
  output logic [31:0]  axis_dma_read_cmd_length,
  input  logic         axis_dma_read_data_valid,
  output logic         axis_dma_read_data_ready,
  input  logic [511:0] axis_dma_read_data_data,
  input  logic [63:0]  axis_dma_read_data_keep,
  input  logic         axis_dma_read_data_last,
  input  logic [63:0]  transfer_base_addr,
  input  logic [31:0]  transfer_start_page,
  input  logic [31:0]  transfer_length,
  input  logic [31:0]  transfer_offset,
  input  logic [31:0]  work_page_size,
  input  logic         transfer_start,
  input  logic [31:0]  gpu_write_count,
  output logic [31:0]  gpu_read_count,
  output logic [31:0]  error_cnt,
  output logic [31:0]  error_index,
  output logic         rx_done
);
  localparam int CW = CTRL_NUM > 1 ? $clog2(CTRL_NUM) : 1;
  typedef enum logic [3:0] {IDLE, START, WAIT_AVAIL, CTRL_CMD, CTRL_DATA, DATA_CMD, DATA_DATA, JUDGE, END} state_t;
  state_t state, state_nxt;
  logic start_s1, start_s2, err_seen;
  logic [63:0] ctrl_base, page_base;
  logic [31:0] remain, rec_page, rec_len, beat, remain_nxt;
  logic [CW-1:0] ctrl_idx;
  logic [511:0] d;
  logic start_edge, rd_fire, stale, rec_ok, last_beat, payload_bad, last_bad, unused_ok;
  assign d = axis_dma_read_data_data;
  assign start_edge = start_s1 & ~start_s2;
  assign rd_fire = axis_dma_read_data_valid & axis_dma_read_data_ready;
  // a clear flag or an old ctrl index means the producer has not published this slot yet
  assign stale = ~d[511] | (d[63:32] != 32'(ctrl_idx));
  assign rec_ok = axis_dma_read_data_last & (d[95:64] < work_page_size) & (d[31:0] != '0) &
                  (d[5:0] == '0) & (d[31:0] <= 32'(PAGE_SIZE));
  assign last_beat = beat == (rec_len >> 6) - 32'd1;
  assign payload_bad = d[31:0] != beat + transfer_offset;
  assign last_bad = axis_dma_read_data_last != last_beat;
  assign remain_nxt = remain > rec_len ? remain - rec_len : '0;
  assign unused_ok = &{1'b0, axis_dma_read_data_keep, d[510:96]};
  always_ff @(posedge clk)
    state <= !rstn ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = start_edge ? START : IDLE;
      START:      state_nxt = WAIT_AVAIL;
      WAIT_AVAIL: state_nxt = (gpu_write_count - gpu_read_count) != '0 ? CTRL_CMD : WAIT_AVAIL;
      CTRL_CMD:   state_nxt = axis_dma_read_cmd_ready ? CTRL_DATA : CTRL_CMD;
      CTRL_DATA:  state_nxt = !rd_fire ? CTRL_DATA : stale ? WAIT_AVAIL : rec_ok ? DATA_CMD : END;
      DATA_CMD:   state_nxt = axis_dma_read_cmd_ready ? DATA_DATA : DATA_CMD;
      DATA_DATA:  state_nxt = rd_fire && last_beat ? JUDGE : DATA_DATA;
      JUDGE:      state_nxt = remain_nxt == '0 ? END : WAIT_AVAIL;
      END:        state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end
  always_comb begin
    axis_dma_read_cmd_valid = state == CTRL_CMD || state == DATA_CMD;
    axis_dma_read_cmd_address = state == CTRL_CMD ? ctrl_base + (64'(ctrl_idx) << 6) :
                                state == DATA_CMD ? page_base + 64'(rec_page) * 64'(PAGE_SIZE) : '0;
    axis_dma_read_cmd_length = state == CTRL_CMD ? 32'h40 : state == DATA_CMD ? rec_len : '0;
    axis_dma_read_data_ready = state == CTRL_DATA || state == DATA_DATA;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      err_seen <= 1'b0;
      ctrl_base <= '0;
      page_base <= '0;
      remain <= '0;
      rec_page <= '0;
      rec_len <= '0;
      beat <= '0;
      ctrl_idx <= '0;
      gpu_read_count <= '0;
      error_cnt <= '0;
      error_index <= '0;
      rx_done <= 1'b0;
    end else begin
      start_s1 <= transfer_start;
      start_s2 <= start_s1;
      if (state == START) begin
        ctrl_base <= transfer_base_addr;
        page_base <= transfer_base_addr + 64'(transfer_start_page) * 64'(PAGE_SIZE);
        remain <= transfer_length;
        ctrl_idx <= '0;
        error_cnt <= '0;
        error_index <= '0;
        err_seen <= 1'b0;
        rx_done <= 1'b0;
      end
      if (state == CTRL_DATA && rd_fire) begin
        rec_page <= d[95:64];
        rec_len <= d[31:0];
        if (!stale && !rec_ok) error_cnt <= error_cnt + 32'd1;
      end
      if (state == DATA_CMD) beat <= '0;
      if (state == DATA_DATA && rd_fire) begin
        beat <= beat + 32'd1;
        error_cnt <= error_cnt + 32'(payload_bad) + 32'(last_bad);
        if (payload_bad && !err_seen) begin
          error_index <= beat;
          err_seen <= 1'b1;
        end
      end
      if (state == JUDGE) begin
        gpu_read_count <= gpu_read_count + 32'd1;
        remain <= remain_nxt;
        ctrl_idx <= ctrl_idx == CW'(CTRL_NUM - 1) ? '0 : ctrl_idx + 1'b1;
      end
      if (state == END) rx_done <= 1'b1;
    end
  end
endmodule
